// File: rtl/coin_classifier.sv
// coin_classifier: serial MSB-first diameter capture, classified against programmable [lo,hi] windows.
// Optional per-coin/reject counters are enabled by defining COIN_CLASSIFIER_COUNT_EN.
`default_nettype none

module coin_classifier #(
    parameter int DIAM_W    = 10,
    parameter int NUM_COINS = 4,
    parameter int CNT_W     = 8,
    parameter logic [NUM_COINS*DIAM_W-1:0] DEF_LO = {10'd745, 10'd830, 10'd700, 10'd950},
    parameter logic [NUM_COINS*DIAM_W-1:0] DEF_HI = {10'd755, 10'd840, 10'd710, 10'd960},
    localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              write,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DIAM_W-1:0] cfg_lo,
    input  logic [DIAM_W-1:0] cfg_hi,
`ifdef COIN_CLASSIFIER_COUNT_EN
    input  logic [IDX_W-1:0]  cnt_sel,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_out,
`endif
    output logic              coin_valid,
    output logic [IDX_W-1:0]  coin_id,
    output logic              reject,
    output logic [DIAM_W-1:0] diam_out,
    output logic              busy
);

    localparam int              BC_W    = $clog2(DIAM_W + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(DIAM_W);
    localparam logic [BC_W-1:0] BC_SAT  = BC_W'(DIAM_W + 1);

    generate
        if (DIAM_W < 2 || NUM_COINS < 1 || CNT_W < 1) begin : g_bad_params
            $error("coin_classifier: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT    = 2'd1,
        S_CLASSIFY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIAM_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic              coin_valid_q, coin_valid_d;
    logic              reject_q, reject_d;
    logic [IDX_W-1:0]  coin_id_q, coin_id_d;
    logic [DIAM_W-1:0] diam_q, diam_d;

    logic [DIAM_W-1:0] lo_q [NUM_COINS];
    logic [DIAM_W-1:0] hi_q [NUM_COINS];

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (lo_q[i] <= shreg_q && shreg_q <= hi_q[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        coin_valid_d = 1'b0;
        reject_d     = 1'b0;
        coin_id_d    = coin_id_q;
        diam_d       = diam_q;
        case (state_q)
            S_IDLE: begin
                if (write) begin
                    shreg_d  = {{(DIAM_W-1){1'b0}}, serial_in};
                    bitcnt_d = BC_W'(1);
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (write) begin
                    shreg_d = {shreg_q[DIAM_W-2:0], serial_in};
                    if (bitcnt_q != BC_SAT) begin
                        bitcnt_d = bitcnt_q + BC_W'(1);
                    end
                end else begin
                    state_d = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                // Any write bit sampled here is intentionally dropped.
                diam_d  = shreg_q;
                state_d = S_IDLE;
                if (bitcnt_q != BC_FULL) begin
                    reject_d = 1'b1;
                end else if (hit) begin
                    coin_valid_d = 1'b1;
                    coin_id_d    = hit_idx;
                end else begin
                    reject_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            coin_valid_q <= 1'b0;
            reject_q     <= 1'b0;
            coin_id_q    <= '0;
            diam_q       <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            coin_valid_q <= coin_valid_d;
            reject_q     <= reject_d;
            coin_id_q    <= coin_id_d;
            diam_q       <= diam_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_COINS; i++) begin
            if (reset) begin
                lo_q[i] <= DEF_LO[i*DIAM_W +: DIAM_W];
                hi_q[i] <= DEF_HI[i*DIAM_W +: DIAM_W];
            end else if (cfg_we && cfg_idx == IDX_W'(i)) begin
                lo_q[i] <= cfg_lo;
                hi_q[i] <= cfg_hi;
            end
        end
    end

`ifdef COIN_CLASSIFIER_COUNT_EN
    // Entry NUM_COINS holds the reject count.
    logic [CNT_W-1:0] cnt_q [NUM_COINS+1];

    always_ff @(posedge clk) begin
        for (int i = 0; i <= NUM_COINS; i++) begin
            if (reset || cnt_clr) begin
                cnt_q[i] <= '0;
            end else if (i < NUM_COINS) begin
                if (coin_valid_d && coin_id_d == IDX_W'(i) && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end else if (reject_d && cnt_q[i] != '1) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cnt_out = '0;
        for (int i = 0; i <= NUM_COINS; i++) begin
            if (int'(cnt_sel) == i) begin
                cnt_out = cnt_q[i];
            end
        end
    end
`endif

    assign coin_valid = coin_valid_q;
    assign reject     = reject_q;
    assign coin_id    = coin_id_q;
    assign diam_out   = diam_q;
    assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_coin_classifier.sv
// Scoreboard bench for coin_classifier: randomized and directed frames against a window-list reference model.
`default_nettype none

module tb_coin_classifier;

    localparam int DW = 10;
    localparam int NC = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          serial_in;
    logic          write;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [DW-1:0] cfg_lo;
    logic [DW-1:0] cfg_hi;
    logic          coin_valid;
    logic [IW-1:0] coin_id;
    logic          reject;
    logic [DW-1:0] diam_out;
    logic          busy;

    coin_classifier dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .write      (write),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_lo     (cfg_lo),
        .cfg_hi     (cfg_hi),
        .coin_valid (coin_valid),
        .coin_id    (coin_id),
        .reject     (reject),
        .diam_out   (diam_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit is_coin;
        int id;
        int diam;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   mlo[NC];
    int   mhi[NC];
    bit   gap1_flag = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        mlo = '{950, 700, 830, 745};
        mhi = '{960, 710, 840, 755};
    endtask

    function automatic int model_class(input int v);
        for (int i = 0; i < NC; i++) begin
            if (mlo[i] <= v && v <= mhi[i]) return i;
        end
        return -1;
    endfunction

    task automatic cfg(input int idx, input int lo, input int hi);
        cfg_we  = 1'b1;
        cfg_idx = IW'(idx);
        cfg_lo  = DW'(lo);
        cfg_hi  = DW'(hi);
        tick();
        cfg_we  = 1'b0;
        mlo[idx] = lo;
        mhi[idx] = hi;
    endtask

    // A gap of one low cycle means the next frame's first bit lands in the classify cycle and is lost.
    task automatic frame(input int v, input int len, input int gap,
                         input bit do_cfg = 1'b0, input int cidx = 0, input int clo = 0, input int chi = 0);
        exp_t e;
        int   elen;
        int   ev;
        int   c;
        int   k = 0;
        for (int b = len - 1; b >= 0; b--) begin
            write     = 1'b1;
            serial_in = ((v >> b) & 1) == 1;
            if (b == len - 2 && !gap1_flag) check("busy_in_frame", int'(busy), 1);
            if (b == 0) k = cyc;
            tick();
        end
        elen   = gap1_flag ? len - 1 : len;
        ev     = v & ((1 << elen) - 1);
        e.diam = ev & ((1 << DW) - 1);
        e.cyc  = k + 3;
        if (elen != DW) begin
            e.is_coin = 1'b0;
            e.id      = 0;
        end else begin
            c         = model_class(e.diam);
            e.is_coin = (c >= 0);
            e.id      = c;
        end
        sb.push_back(e);
        write     = 1'b0;
        serial_in = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (do_cfg && g == 1) begin
                cfg_we  = 1'b1;
                cfg_idx = IW'(cidx);
                cfg_lo  = DW'(clo);
                cfg_hi  = DW'(chi);
            end
            tick();
            cfg_we = 1'b0;
        end
        if (do_cfg) begin
            mlo[cidx] = clo;
            mhi[cidx] = chi;
        end
        gap1_flag = (gap == 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (coin_valid || reject)) begin
            if (coin_valid && reject) check("pulse_mutex", 1, 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                check("coin_valid", int'(coin_valid), int'(e.is_coin));
                check("reject", int'(reject), int'(!e.is_coin));
                if (e.is_coin) check("coin_id", int'(coin_id), e.id);
                check("diam_out", int'(diam_out), e.diam);
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int idx;
        int v;
        int len;
        int lo;
        int hi;
        reset     = 1'b1;
        serial_in = 1'b0;
        write     = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_lo    = '0;
        cfg_hi    = '0;
        set_defaults();
        tick();
        tick();
        reset = 1'b0;
        check("rst_coin_valid", int'(coin_valid), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_coin_id", int'(coin_id), 0);
        check("rst_diam_out", int'(diam_out), 0);
        check("rst_busy", int'(busy), 0);
        tick();

        // Default windows and their edges
        frame(955, 10, 2);
        frame(700, 10, 2);
        frame(710, 10, 2);
        frame(699, 10, 2);
        frame(711, 10, 2);
        frame(745, 10, 2);

        // Length errors
        frame(int'($urandom_range(0, 511)), 9, 2);
        frame(int'($urandom_range(0, 4095)), 12, 2);

        // Back-to-back: one low cycle loses a bit, two low cycles do not
        frame(835, 10, 1);
        frame(835, 10, 2);
        frame(835, 10, 2);

        // Reprogramming and priority
        cfg(2, 500, 520);
        frame(510, 10, 2);
        cfg(3, 505, 515);
        frame(510, 10, 2);
        cfg(2, 600, 500);
        frame(510, 10, 2);
        // Config landing on the classify edge must not affect that frame
        frame(510, 10, 2, 1'b1, 3, 0, 0);
        frame(510, 10, 2);

        // Reset mid-frame
        for (int b = 9; b >= 5; b--) begin
            write     = 1'b1;
            serial_in = ((835 >> b) & 1) == 1;
            tick();
        end
        write = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_defaults();
        gap1_flag = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_diam_out", int'(diam_out), 0);
        tick();
        frame(835, 10, 2);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idx = int'($urandom_range(0, NC - 1));
                lo  = int'($urandom_range(0, 1000));
                hi  = ($urandom_range(0, 7) == 0) ? lo - 1 : lo + int'($urandom_range(0, 23));
                if (hi < 0) hi = 0;
                cfg(idx, lo, hi);
            end
            idx = int'($urandom_range(0, NC - 1));
            if (mhi[idx] >= mlo[idx]) v = mlo[idx] - 2 + int'($urandom_range(0, mhi[idx] - mlo[idx] + 4));
            else v = int'($urandom_range(0, 1023));
            if (v < 0) v = 0;
            if (v > 1023) v = 1023;
            len = 10;
            if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 1) ? 11 : 9;
            if (len == 9) v = v & 511;
            if ($urandom_range(0, 7) == 0)
                frame(v, len, 2, 1'b1, int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 1000)), 1023);
            else
                frame(v, len, int'($urandom_range(2, 3)));
        end

        for (int i = 0; i < 6; i++) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
